// File: rtl/multiword_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_seq_if
// Brief    : Operand/result handshake and 16-bit adder bus for
//            multiword_add_seq. Op_sub exists only when
//            MULTIWORD_ADD_SEQ_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface multiword_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  // upstream operand handshake
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] Op_A;
  logic [W-1:0] Op_B;
  logic         Op_Cin;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  logic         Op_sub;
`endif
  // external combinational 16-bit adder
  logic [15:0]  Add_A;
  logic [15:0]  Add_B;
  logic         Add_Cin;
  logic [15:0]  Add_S;
  logic         Add_Cout;
  // downstream result handshake
  logic         Out_valid;
  logic         Out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;

  // sequencer side
  modport slave (
    input  In_valid, Op_A, Op_B, Op_Cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    input  Op_sub,
`endif
    input  Add_S, Add_Cout, Out_ready,
    output In_ready, Add_A, Add_B, Add_Cin,
    output Out_valid, Sum, Cout, Overflow
  );

  // environment side: operand source, adder and result sink
  modport master (
    output In_valid, Op_A, Op_B, Op_Cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    output Op_sub,
`endif
    output Add_S, Add_Cout, Out_ready,
    input  In_ready, Add_A, Add_B, Add_Cin,
    input  Out_valid, Sum, Cout, Overflow
  );
endinterface
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_seq
// Brief    : Performs a (16*WORDS)-bit add by driving an external 16-bit
//            combinational adder one slice per cycle, LSB slice first,
//            with the carry rippled through a register.
//            Optional: MULTIWORD_ADD_SEQ_SUB_EN adds Op_sub (A-B mode).
// Revision : 1.0 - initial release
// ============================================================================
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  multiword_add_seq_if.slave  bus
);
  localparam int W     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  logic             sub_q,   sub_d;
`endif

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic        in_ready;
  logic        out_valid;

  // Next-state, datapath updates and handshake/adder outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    sub_d     = sub_q;
`endif
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.In_valid) begin
          a_d     = bus.Op_A;
          b_d     = bus.Op_B;
          idx_d   = '0;
          state_d = S_RUN;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
          sub_d   = bus.Op_sub;
          // subtraction is A + ~B + 1, so the initial carry is forced high
          carry_d = bus.Op_sub ? 1'b1 : bus.Op_Cin;
`else
          carry_d = bus.Op_Cin;
`endif
        end
      end

      S_RUN: begin
        add_a = a_q[16*int'(idx_q) +: 16];
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        add_b = sub_q ? ~b_q[16*int'(idx_q) +: 16] : b_q[16*int'(idx_q) +: 16];
`else
        add_b = b_q[16*int'(idx_q) +: 16];
`endif
        add_cin = carry_q;
        sum_d[16*int'(idx_q) +: 16] = bus.Add_S;
        carry_d = bus.Add_Cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = bus.Add_Cout;
          // A^B^S on the top bit recovers the carry into bit 15
          ovf_d   = add_a[15] ^ add_b[15] ^ bus.Add_S[15] ^ bus.Add_Cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (bus.Out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = out_valid;
  assign bus.Add_A     = add_a;
  assign bus.Add_B     = add_b;
  assign bus.Add_Cin   = add_cin;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_add_seq
// Brief    : Self-checking bench for multiword_add_seq with a behavioural
//            16-bit adder; table vectors, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  multiword_add_seq_if #(.WORDS(WORDS)) bus ();

  // external combinational 16-bit adder
  assign {bus.Add_Cout, bus.Add_S} = {1'b0, bus.Add_A} + {1'b0, bus.Add_B} + {16'd0, bus.Add_Cin};

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // whole-word reference: A + B + cin, or A + ~B + 1 when subtracting
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    bus.Op_A   = a;
    bus.Op_B   = b;
    bus.Op_Cin = cin;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    bus.Op_sub = sub;
`else
    if (sub) $display("note: sub requested without subtract support");
`endif
  endtask

  // Called at a negedge with the DUT expected idle; returns at the negedge
  // after the completion handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int bp_cycles,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output logic [WORDS-1:0] cins);
    int k;
    int lat;
    logic [W-1:0] s0;
    k = 0;
    while (!bus.In_ready && k < 50) begin
      @(negedge Clk);
      k++;
    end
    chk("in_ready_before_accept", {63'd0, bus.In_ready}, 64'd1);
    drive_ops(a, b, cin, sub);
    bus.In_valid  = 1'b1;
    bus.Out_ready = 1'b0;
    @(negedge Clk);
    // operands are latched: scramble them after the accept edge
    bus.In_valid = 1'b0;
    drive_ops({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    lat  = 0;
    cins = '0;
    while (!bus.Out_valid && lat < 20) begin
      if (lat < WORDS) cins[lat] = bus.Add_Cin;
      chk("in_ready_busy", {63'd0, bus.In_ready}, 64'd0);
      @(negedge Clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(WORDS));
    s0 = bus.Sum;
    for (int i = 0; i < bp_cycles; i++) begin
      bus.In_valid = 1'b1;
      drive_ops({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      @(negedge Clk);
      chk("bp_sum_stable", bus.Sum, s0);
      chk("bp_valid_held", {63'd0, bus.Out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, bus.In_ready}, 64'd0);
    end
    bus.In_valid = 1'b0;
    chk("done_add_a_zero", {48'd0, bus.Add_A}, 64'd0);
    s  = bus.Sum;
    co = bus.Cout;
    ov = bus.Overflow;
    bus.Out_ready = 1'b1;
    @(negedge Clk);
    bus.Out_ready = 1'b0;
    chk("post_hs_valid", {63'd0, bus.Out_valid}, 64'd0);
    chk("post_hs_in_ready", {63'd0, bus.In_ready}, 64'd1);
    chk("post_hs_sum_hold", bus.Sum, s);
  endtask

  task automatic check_result(input string tag, input vec_t v, input int bp);
    logic [W-1:0]     s;
    logic             co, ov;
    logic [WORDS-1:0] cins;
    run_op(v.a, v.b, v.cin, v.sub, bp, s, co, ov, cins);
    chk({tag, "_sum"}, s, v.s);
    chk({tag, "_cout"}, {63'd0, co}, {63'd0, v.co});
    chk({tag, "_ovf"}, {63'd0, ov}, {63'd0, v.ov});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [W-1:0]     s;
    logic             co, ov;
    logic [WORDS-1:0] cins;

    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);

    tbl.push_back('{64'h0000_0000_0000_96D9, 64'h0000_0000_0000_F7DE, 1'b0, 1'b0,
                    64'h0000_0000_0001_8EB7, 1'b0, 1'b0});
    tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
                    64'h0000_0000_0000_0000, 1'b1, 1'b0});
    tbl.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1});
    tbl.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                    64'h0000_0000_0000_0000, 1'b1, 1'b1});
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    tbl.push_back('{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
    tbl.push_back('{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
`endif

    // reset state
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_in_ready", {63'd0, bus.In_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.Out_valid}, 64'd0);
    chk("rst_sum", bus.Sum, 64'd0);
    chk("rst_cout", {63'd0, bus.Cout}, 64'd0);
    chk("rst_ovf", {63'd0, bus.Overflow}, 64'd0);
    chk("rst_add_a", {48'd0, bus.Add_A}, 64'd0);
    chk("rst_add_cin", {63'd0, bus.Add_Cin}, 64'd0);

    // table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      check_result($sformatf("vec%0d", i), tbl[i], 0);
    end

    // carry ripple sequence on FFFF..FF + 1
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, s, co, ov, cins);
    chk("ripple_cins", {60'd0, cins}, 64'hE);
    chk("ripple_sum", s, 64'd0);

    // back-pressure for 5 cycles, then immediate re-accept
    v = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
          64'h2222_2222_2222_2212, 1'b0, 1'b0};
    check_result("bp", v, 5);
    v = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
          64'h0001_0000_0001_0000, 1'b0, 1'b0};
    check_result("bp_next", v, 0);

    // reset while RUN at idx=2
    drive_ops(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    bus.In_valid = 1'b1;
    @(negedge Clk);
    bus.In_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("abort_out_valid", {63'd0, bus.Out_valid}, 64'd0);
    chk("abort_sum", bus.Sum, 64'd0);
    chk("abort_in_ready", {63'd0, bus.In_ready}, 64'd1);
    chk("abort_cout", {63'd0, bus.Cout}, 64'd0);
    @(negedge Clk);
    chk("abort_stays_idle", {63'd0, bus.Out_valid}, 64'd0);
    v = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0,
          64'h0000_0000_0000_0000, 1'b1, 1'b0};
    check_result("after_abort", v, 0);

    // randomized operations against the whole-word model
    for (int i = 0; i < 24; i++) begin
      v.a = {$urandom, $urandom};
      v.b = {$urandom, $urandom};
      if (i % 6 == 1) v.b = ~v.a;
      if (i % 6 == 2) v.a = {1'b0, {(W-1){1'b1}}};
      v.cin = 1'($urandom);
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      v.sub = 1'($urandom);
`else
      v.sub = 1'b0;
`endif
      model(v.a, v.b, v.cin, v.sub, v.s, v.co, v.ov);
      check_result($sformatf("rnd%0d", i), v, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
